// File: rtl/ex_reg.sv
// EX/MEM pipeline register: captures ALU result and ID/EX control fields, turns a
// qualified ALU overflow into an exception, and keeps a saturating overflow count.
module ex_reg #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 30,
  parameter int REG_ADDR_W = 5,
  parameter int OFCNT_W    = 8
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  IdEn,
  input  logic [PC_W-1:0]       IdPc,
  input  logic [3:0]            AluOp,
  input  logic [DATA_W-1:0]     AluOut,
  input  logic                  AluOF,
  input  logic [REG_ADDR_W-1:0] IdDstAddr,
  input  logic                  IdGprWe,
  input  logic [1:0]            IdMemOp,
  input  logic [DATA_W-1:0]     IdMemWrData,
  output logic                  ExEn,
  output logic [PC_W-1:0]       ExPc,
  output logic [DATA_W-1:0]     ExAluOut,
  output logic [REG_ADDR_W-1:0] ExDstAddr,
  output logic                  ExGprWe,
  output logic [1:0]            ExMemOp,
  output logic [DATA_W-1:0]     ExMemWrData,
  output logic [1:0]            ExExpCode,
  output logic [OFCNT_W-1:0]    ExOfCount
);

  localparam logic [3:0] ALU_OP_ADDS = 4'd1;
  localparam logic [3:0] ALU_OP_SUBS = 4'd3;
  localparam logic [1:0] MEM_OP_NOP  = 2'd0;
  localparam logic [1:0] EXP_NO      = 2'd0;
  localparam logic [1:0] EXP_OVERFLOW = 2'd1;

  logic                  en_q, en_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [DATA_W-1:0]     alu_q, alu_d;
  logic [REG_ADDR_W-1:0] dst_q, dst_d;
  logic                  gpr_we_q, gpr_we_d;
  logic [1:0]            mem_op_q, mem_op_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [1:0]            exp_q, exp_d;
  logic [OFCNT_W-1:0]    ofcnt_q, ofcnt_d;

  logic of_qual;

  // Only signed add/sub of a valid entry can raise overflow; OF is undefined otherwise.
  assign of_qual = IdEn & AluOF & ((AluOp == ALU_OP_ADDS) | (AluOp == ALU_OP_SUBS));

  always_comb begin
    en_d      = en_q;
    pc_d      = pc_q;
    alu_d     = alu_q;
    dst_d     = dst_q;
    gpr_we_d  = gpr_we_q;
    mem_op_d  = mem_op_q;
    wr_data_d = wr_data_q;
    exp_d     = exp_q;
    ofcnt_d   = ofcnt_q;
    if (Flush) begin
      en_d      = 1'b0;
      pc_d      = '0;
      alu_d     = '0;
      dst_d     = '0;
      gpr_we_d  = 1'b0;
      mem_op_d  = MEM_OP_NOP;
      wr_data_d = '0;
      exp_d     = EXP_NO;
    end else if (!Stall) begin
      en_d      = IdEn;
      pc_d      = IdPc;
      alu_d     = AluOut;
      dst_d     = IdDstAddr;
      wr_data_d = IdMemWrData;
      if (of_qual) begin
        exp_d    = EXP_OVERFLOW;
        gpr_we_d = 1'b0;
        mem_op_d = MEM_OP_NOP;
        if (!(&ofcnt_q)) begin
          ofcnt_d = ofcnt_q + {{(OFCNT_W-1){1'b0}}, 1'b1};
        end
      end else if (IdEn) begin
        exp_d    = EXP_NO;
        gpr_we_d = IdGprWe;
        mem_op_d = IdMemOp;
      end else begin
        exp_d    = EXP_NO;
        gpr_we_d = 1'b0;
        mem_op_d = MEM_OP_NOP;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      en_q      <= 1'b0;
      pc_q      <= '0;
      alu_q     <= '0;
      dst_q     <= '0;
      gpr_we_q  <= 1'b0;
      mem_op_q  <= MEM_OP_NOP;
      wr_data_q <= '0;
      exp_q     <= EXP_NO;
      ofcnt_q   <= '0;
    end else begin
      en_q      <= en_d;
      pc_q      <= pc_d;
      alu_q     <= alu_d;
      dst_q     <= dst_d;
      gpr_we_q  <= gpr_we_d;
      mem_op_q  <= mem_op_d;
      wr_data_q <= wr_data_d;
      exp_q     <= exp_d;
      ofcnt_q   <= ofcnt_d;
    end
  end

  assign ExEn        = en_q;
  assign ExPc        = pc_q;
  assign ExAluOut    = alu_q;
  assign ExDstAddr   = dst_q;
  assign ExGprWe     = gpr_we_q;
  assign ExMemOp     = mem_op_q;
  assign ExMemWrData = wr_data_q;
  assign ExExpCode   = exp_q;
  assign ExOfCount   = ofcnt_q;

endmodule

// File: tb/tb_ex_reg.sv
// Self-checking bench for ex_reg: directed scenarios plus randomized traffic
// compared against a behavioural model of the stage.
module tb_ex_reg;

  localparam int DATA_W     = 32;
  localparam int PC_W       = 30;
  localparam int REG_ADDR_W = 5;
  localparam int OFCNT_W    = 8;

  localparam logic [3:0] ALU_OP_ADDU = 4'd0;
  localparam logic [3:0] ALU_OP_ADDS = 4'd1;
  localparam logic [3:0] ALU_OP_SUBS = 4'd3;
  localparam logic [3:0] ALU_OP_AND  = 4'd4;
  localparam logic [1:0] MEM_LOAD    = 2'd1;
  localparam logic [1:0] MEM_STORE   = 2'd2;

  // clock / reset
  logic Clk;
  logic Reset_N;
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  logic                  Stall, Flush, IdEn, AluOF, IdGprWe;
  logic [PC_W-1:0]       IdPc;
  logic [3:0]            AluOp;
  logic [DATA_W-1:0]     AluOut, IdMemWrData;
  logic [REG_ADDR_W-1:0] IdDstAddr;
  logic [1:0]            IdMemOp;
  logic                  ExEn, ExGprWe;
  logic [PC_W-1:0]       ExPc;
  logic [DATA_W-1:0]     ExAluOut, ExMemWrData;
  logic [REG_ADDR_W-1:0] ExDstAddr;
  logic [1:0]            ExMemOp, ExExpCode;
  logic [OFCNT_W-1:0]    ExOfCount;

  ex_reg #(
    .DATA_W(DATA_W), .PC_W(PC_W), .REG_ADDR_W(REG_ADDR_W), .OFCNT_W(OFCNT_W)
  ) dut (
    .Clk(Clk), .Reset_N(Reset_N), .Stall(Stall), .Flush(Flush), .IdEn(IdEn),
    .IdPc(IdPc), .AluOp(AluOp), .AluOut(AluOut), .AluOF(AluOF),
    .IdDstAddr(IdDstAddr), .IdGprWe(IdGprWe), .IdMemOp(IdMemOp),
    .IdMemWrData(IdMemWrData), .ExEn(ExEn), .ExPc(ExPc), .ExAluOut(ExAluOut),
    .ExDstAddr(ExDstAddr), .ExGprWe(ExGprWe), .ExMemOp(ExMemOp),
    .ExMemWrData(ExMemWrData), .ExExpCode(ExExpCode), .ExOfCount(ExOfCount)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // behavioural model of what the memory stage should see
  logic        m_en, m_we;
  logic [63:0] m_pc, m_alu, m_dst, m_wd;
  int          m_memop, m_exp, m_cnt;

  task automatic model_reset();
    m_en = 0; m_we = 0; m_pc = 0; m_alu = 0; m_dst = 0; m_wd = 0;
    m_memop = 0; m_exp = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit ovf;
    ovf = IdEn && AluOF && (AluOp == ALU_OP_ADDS || AluOp == ALU_OP_SUBS);
    if (Flush) begin
      m_en = 0; m_we = 0; m_memop = 0; m_exp = 0;
      m_pc = 0; m_alu = 0; m_dst = 0; m_wd = 0;
    end else if (!Stall) begin
      m_en = IdEn; m_pc = IdPc; m_alu = AluOut; m_dst = IdDstAddr; m_wd = IdMemWrData;
      if (ovf) begin
        m_exp = 1; m_we = 0; m_memop = 0;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else if (IdEn) begin
        m_exp = 0; m_we = IdGprWe; m_memop = IdMemOp;
      end else begin
        m_exp = 0; m_we = 0; m_memop = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".en"},    ExEn,        m_en);
    check({tag, ".pc"},    ExPc,        m_pc);
    check({tag, ".alu"},   ExAluOut,    m_alu);
    check({tag, ".dst"},   ExDstAddr,   m_dst);
    check({tag, ".we"},    ExGprWe,     m_we);
    check({tag, ".memop"}, ExMemOp,     64'(m_memop));
    check({tag, ".wd"},    ExMemWrData, m_wd);
    check({tag, ".exp"},   ExExpCode,   64'(m_exp));
    check({tag, ".cnt"},   ExOfCount,   64'(m_cnt));
  endtask

  // driver tasks
  task automatic drive(input logic en, input logic [3:0] op, input logic [31:0] out,
                       input logic of, input logic [4:0] dst, input logic we,
                       input logic [1:0] memop, input logic st, input logic fl);
    IdEn = en; AluOp = op; AluOut = out; AluOF = of; IdDstAddr = dst;
    IdGprWe = we; IdMemOp = memop; Stall = st; Flush = fl;
    IdPc = PC_W'($urandom()); IdMemWrData = $urandom();
  endtask

  task automatic drive_random(input int stall_pct, input int flush_pct);
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    if ($urandom_range(0, 2) == 0) op = ($urandom_range(0, 1) == 0) ? ALU_OP_ADDS : ALU_OP_SUBS;
    drive(1'($urandom_range(0, 3) != 0), op, $urandom(), 1'($urandom()),
          5'($urandom()), 1'($urandom()), 2'($urandom_range(0, 2)),
          1'($urandom_range(0, 99) < stall_pct), 1'($urandom_range(0, 99) < flush_pct));
  endtask

  task automatic cycle(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  logic [31:0] held_alu;

  initial begin
    // reset asserted with nonzero inputs and no clock edge yet
    Reset_N = 1'b0;
    drive(1, ALU_OP_ADDS, 32'hdead_beef, 1, 5'd7, 1, MEM_STORE, 0, 0);
    model_reset();
    #2;
    check_all("reset");
    check("reset.memop_const", ExMemOp, 0);
    @(negedge Clk);
    Reset_N = 1'b1;

    // normal pass
    drive(1, ALU_OP_ADDU, 32'h0000_1234, 0, 5'd3, 1, 2'd0, 0, 0);
    cycle("normal");
    check("normal.alu_const", ExAluOut, 32'h1234);
    check("normal.dst_const", ExDstAddr, 3);

    // qualified overflow
    drive(1, ALU_OP_ADDS, $urandom(), 1, 5'd9, 1, MEM_STORE, 0, 0);
    cycle("ovf");
    check("ovf.exp_const", ExExpCode, 1);
    check("ovf.cnt_const", ExOfCount, 1);

    // OF on a non-arithmetic op is ignored
    drive(1, ALU_OP_AND, $urandom(), 1, 5'd10, 1, MEM_STORE, 0, 0);
    cycle("and_of");
    check("and_of.we_const", ExGprWe, 1);
    check("and_of.cnt_const", ExOfCount, 1);

    // stall holds entry A while inputs change
    drive(1, ALU_OP_ADDU, 32'haaaa_5555, 0, 5'd12, 1, MEM_LOAD, 0, 0);
    cycle("load_a");
    held_alu = ExAluOut;
    for (int i = 0; i < 3; i++) begin
      drive_random(0, 0);
      Stall = 1'b1;
      cycle("stall");
      check("stall.alu_const", ExAluOut, 32'haaaa_5555);
    end
    drive_random(0, 0);
    Stall = 1'b1; Flush = 1'b1;
    cycle("stall_flush");
    check("flush.alu_zero", ExAluOut, 0);

    // bubble with overflow-looking inputs
    drive(0, ALU_OP_SUBS, $urandom(), 1, 5'd4, 1, MEM_LOAD, 0, 0);
    cycle("bubble");
    check("bubble.cnt_const", ExOfCount, 1);

    // saturation
    for (int i = 0; i < 260; i++) begin
      drive(1, (i % 2 == 0) ? ALU_OP_ADDS : ALU_OP_SUBS, $urandom(), 1,
            5'($urandom()), 1, 2'($urandom_range(0, 2)), 0, 0);
      cycle("sat");
    end
    check("sat.cnt_const", ExOfCount, 255);

    // reset mid-stall: takes effect without a clock edge
    drive_random(0, 0);
    Stall = 1'b1;
    @(negedge Clk);
    Reset_N = 1'b0;
    #1;
    model_reset();
    check_all("rst_stall");
    @(negedge Clk);
    Reset_N = 1'b1;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive_random(15, 8);
      cycle("rand");
    end

    // reset mid-flush
    drive_random(0, 0);
    Flush = 1'b1;
    @(negedge Clk);
    Reset_N = 1'b0;
    #1;
    model_reset();
    check_all("rst_flush");
    @(negedge Clk);
    Reset_N = 1'b1;
    drive_random(0, 0);
    cycle("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
